// File: rtl/gpmc_async_target.sv
// GPMC async 16-bit muxed-AD target: synchronizes host strobes into clk,
// latches the address on ADVn, and turns host writes/reads into register
// write strobes and read requests, returning read data on the AD bus.
module gpmc_async_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gpmc_csn,
  input  logic        gpmc_advn,
  input  logic        gpmc_oen,
  input  logic        gpmc_wen,
  input  logic [1:0]  gpmc_ben,
  inout  wire  [15:0] gpmc_ad,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic [1:0]  reg_wr_be,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data
);

  // {csn, advn, oen, wen, ben[1:0]} at their inactive levels
  localparam logic [5:0] CTL_INACTIVE = 6'b10_1111;

  typedef enum logic [2:0] {IDLE, ADDR, ACCESS, WRITE, READ} state_t;

  logic [5:0]  ctl_sync [SYNC_STAGES];
  logic [15:0] ad_sync  [SYNC_STAGES];
  logic        csn_s, advn_s, oen_s, wen_s;
  logic [1:0]  ben_s;
  logic [15:0] ad_s;
  logic        advn_q, wen_q;
  logic [15:0] ad_q;
  state_t      state_q, state_d;
  logic        addr_load, wr_load, wr_strobe, rd_strobe;
  logic        rd_cap;
  logic [15:0] rd_hold;
  logic        ad_drive;

  // Equal-depth synchronizers keep AD sample-aligned with the strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        ctl_sync[i] <= CTL_INACTIVE;
        ad_sync[i]  <= '0;
      end
    end else begin
      ctl_sync[0] <= {gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen, gpmc_ben};
      ad_sync[0]  <= gpmc_ad;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        ctl_sync[i] <= ctl_sync[i-1];
        ad_sync[i]  <= ad_sync[i-1];
      end
    end
  end

  assign {csn_s, advn_s, oen_s, wen_s, ben_s} = ctl_sync[SYNC_STAGES-1];
  assign ad_s = ad_sync[SYNC_STAGES-1];

  // Previous synchronized sample, for edge detection and address capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      advn_q <= 1'b0;
      wen_q  <= 1'b1;
      ad_q   <= '0;
    end else begin
      advn_q <= advn_s;
      wen_q  <= wen_s;
      ad_q   <= ad_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and datapath control
  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    wr_load   = 1'b0;
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        if (!csn_s) state_d = ADDR;
      end
      ADDR: begin
        if (csn_s) begin
          state_d = IDLE;
        end else if (!advn_q && advn_s) begin
          addr_load = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!wen_s) begin
          wr_load = 1'b1;
          state_d = WRITE;
        end else if (!oen_s) begin
          rd_strobe = 1'b1;
          state_d   = READ;
        end else if (csn_s) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        // WEn release commits even when CSn rises on the same sample
        if (!wen_q && wen_s) begin
          wr_strobe = 1'b1;
          state_d   = IDLE;
        end else if (csn_s) begin
          state_d = IDLE;
        end else if (!wen_s) begin
          wr_load = 1'b1;
        end
      end
      READ: begin
        if (oen_s || csn_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-side outputs: strobes are one cycle, address/data hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_be   <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
    end else begin
      reg_wr_en <= wr_strobe;
      reg_rd_en <= rd_strobe;
      if (addr_load) reg_addr <= ad_q;
      if (wr_load) begin
        reg_wr_data <= ad_s;
        reg_wr_be   <= ~ben_s;
      end
    end
  end

  if (RD_LATENCY == 0) begin : g_rd_nodly
    assign rd_cap = reg_rd_en;
  end else begin : g_rd_dly
    logic [RD_LATENCY-1:0] rd_dly;
    // Delay the read request to the cycle in which reg_rd_data is valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_dly <= '0;
      end else begin
        rd_dly[0] <= reg_rd_en;
        for (int unsigned i = 1; i < RD_LATENCY; i++) rd_dly[i] <= rd_dly[i-1];
      end
    end
    assign rd_cap = rd_dly[RD_LATENCY-1];
  end

  // Read data hold register driven back onto AD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_hold <= '0;
    else if (rd_cap) rd_hold <= reg_rd_data;
  end

  // Drive enable comes straight from the pins so AD releases without sync delay
  assign ad_drive = rst_n && !gpmc_csn && !gpmc_oen && gpmc_wen;
  assign gpmc_ad  = ad_drive ? rd_hold : 'z;

endmodule

// File: tb/tb_gpmc_async_target.sv
// Self-checking bench for gpmc_async_target: host BFM, register-side stub,
// transaction-level reference model and randomized transaction mix.
module tb_gpmc_async_target;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csn = 1'b1, advn = 1'b0, oen = 1'b1, wen = 1'b1;
  logic [1:0]  ben = 2'b11;
  logic        host_drive = 1'b0;
  logic [15:0] host_ad = '0;
  tri0  [15:0] gpmc_ad;
  logic [15:0] reg_addr, reg_wr_data, reg_rd_data;
  logic        reg_wr_en, reg_rd_en;
  logic [1:0]  reg_wr_be;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    int          cyc;
  } xact_t;

  xact_t got_wr[$], got_rd[$], exp_wr[$], exp_rd[$];
  logic [15:0] hold_model = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign gpmc_ad = host_drive ? host_ad : 'z;

  gpmc_async_target #(.SYNC_STAGES(SYNC), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .gpmc_csn(csn), .gpmc_advn(advn),
    .gpmc_oen(oen), .gpmc_wen(wen), .gpmc_ben(ben), .gpmc_ad(gpmc_ad),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_wr_be(reg_wr_be), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data)
  );

  // Register-side stub: data is valid only RD_LAT cycles after the request
  function automatic logic [15:0] stub(input logic [15:0] a);
    return 16'((a ^ 16'h0034) * 16'h9E37 + 16'h1234);
  endfunction

  logic [3:0] rd_sh = '0;
  logic [4:0] rd_win;
  always @(posedge clk) rd_sh <= {rd_sh[2:0], reg_rd_en};
  assign rd_win = {rd_sh, reg_rd_en};
  assign reg_rd_data = rd_win[RD_LAT] ? stub(reg_addr) : 16'hDEAD;

  // Strobe monitor
  always @(negedge clk) begin
    if (reg_wr_en) got_wr.push_back('{reg_addr, reg_wr_data, reg_wr_be, cyc});
    if (reg_rd_en) got_rd.push_back('{reg_addr, 16'h0000, 2'b00, cyc});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic addr_phase(input logic [15:0] addr);
    csn = 1'b0; advn = 1'b0; host_drive = 1'b1; host_ad = addr;
    step(3);
    advn = 1'b1;
    step(2);
    host_drive = 1'b0;
    step(1);
    check_eq("ad_idle", 32'(gpmc_ad), 32'h0);
  endtask

  task automatic host_write(input logic [15:0] addr, input logic [15:0] data,
                            input logic [1:0] be_n, input bit together, input int gap);
    addr_phase(addr);
    host_drive = 1'b1; host_ad = data; ben = be_n; wen = 1'b0;
    step(3);
    wen = 1'b1;
    exp_wr.push_back('{addr, data, ~be_n, cyc});
    if (!together) step(1);
    csn = 1'b1; advn = 1'b0; ben = 2'b11; host_drive = 1'b0;
    step(gap);
  endtask

  task automatic host_read(input logic [15:0] addr, output logic [15:0] val);
    addr_phase(addr);
    oen = 1'b0;
    exp_rd.push_back('{addr, 16'h0000, 2'b00, cyc});
    step(SYNC + RD_LAT + 1);
    check_eq("ad_early", 32'(gpmc_ad), 32'(hold_model));
    step(1);
    check_eq("ad_valid", 32'(gpmc_ad), 32'(stub(addr)));
    step(2);
    val = gpmc_ad;
    check_eq("rd_data", 32'(val), 32'(stub(addr)));
    hold_model = stub(addr);
    oen = 1'b1;
    #1;
    check_eq("ad_z_oen", 32'(gpmc_ad), 32'h0);
    step(1);
    csn = 1'b1; advn = 1'b0;
    step(2);
  endtask

  task automatic host_abort(input logic [15:0] addr);
    addr_phase(addr);
    step(2);
    csn = 1'b1; advn = 1'b0;
    step(3);
  endtask

  task automatic drain();
    xact_t e, g;
    int k = 0;
    while ((got_wr.size() < exp_wr.size() || got_rd.size() < exp_rd.size()) && k < 20) begin
      step(1);
      k++;
    end
    step(2);
    check_eq("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
    check_eq("rd_count", 32'(got_rd.size()), 32'(exp_rd.size()));
    while (exp_wr.size() > 0 && got_wr.size() > 0) begin
      e = exp_wr.pop_front(); g = got_wr.pop_front();
      check_eq("wr_addr", 32'(g.addr), 32'(e.addr));
      check_eq("wr_data", 32'(g.data), 32'(e.data));
      check_eq("wr_be", 32'(g.be), 32'(e.be));
      check_eq("wr_lat", 32'(g.cyc - e.cyc), 32'(SYNC + 1));
    end
    while (exp_rd.size() > 0 && got_rd.size() > 0) begin
      e = exp_rd.pop_front(); g = got_rd.pop_front();
      check_eq("rd_addr", 32'(g.addr), 32'(e.addr));
      check_eq("rd_lat", 32'(g.cyc - e.cyc), 32'(SYNC + 1));
    end
    exp_wr.delete(); got_wr.delete(); exp_rd.delete(); got_rd.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_addr"}, 32'(reg_addr), 32'h0);
    check_eq({tag, "_wdata"}, 32'(reg_wr_data), 32'h0);
    check_eq({tag, "_wbe"}, 32'(reg_wr_be), 32'h0);
    check_eq({tag, "_wen"}, 32'(reg_wr_en), 32'h0);
    check_eq({tag, "_ren"}, 32'(reg_rd_en), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv;
    step(3);
    check_reset_outputs("rst");
    check_eq("ad_rst", 32'(gpmc_ad), 32'h0);
    rst_n = 1'b1;
    step(3);

    host_write(16'h0012, 16'hBEEF, 2'b00, 1'b0, 3);
    drain();

    host_read(16'h0034, rv);
    check_eq("rd_0034", 32'(rv), 32'h1234);
    drain();

    host_write(16'h0001, 16'h1111, 2'b00, 1'b1, 1);
    host_write(16'h0002, 16'h2222, 2'b00, 1'b1, 3);
    drain();

    host_abort(16'h0077);
    drain();
    host_write(16'h0005, 16'hA5A5, 2'b00, 1'b0, 3);
    drain();

    // Reset lands while WEn is still low
    csn = 1'b0; advn = 1'b0; host_drive = 1'b1; host_ad = 16'h00AB;
    step(3);
    advn = 1'b1;
    step(2);
    host_ad = 16'hCAFE; ben = 2'b00; wen = 1'b0;
    step(3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wen = 1'b1; csn = 1'b1; advn = 1'b0; ben = 2'b11; host_drive = 1'b0;
    step(2);
    rst_n = 1'b1;
    hold_model = '0;
    step(3);
    drain();
    host_read(16'h0040, rv);
    drain();

    host_write(16'h0009, 16'h5555, 2'b10, 1'b0, 3);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, d;
      logic [1:0]  b;
      a = 16'($urandom);
      d = 16'($urandom);
      b = 2'($urandom);
      case ($urandom_range(0, 3))
        0: host_write(a, d, b, 1'($urandom), int'($urandom_range(2, 4)));
        1: host_read(a, rv);
        2: host_abort(a);
        default: begin
          host_write(a, d, b, 1'b1, 1);
          host_write(16'(a + 16'd1), 16'(~d), 2'($urandom), 1'b1, 3);
        end
      endcase
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
